// File: rtl/fft_input_loader_if.sv
// Sample-stream and FFT RAM write bundle for fft_input_loader.
// master drives the upstream/FFT-status inputs; slave is the loader itself.
interface fft_input_loader_if #(
  parameter int unsigned ADDR_W = 9
);
  logic               iEN;
  logic               iVALID;
  logic signed [15:0] iSAMPLE;
  logic               iFFT_RDY;
  logic               oREADY;
  logic [15:0]        oDATA;
  logic [ADDR_W-1:0]  oADDR_WR_0;
  logic [ADDR_W-1:0]  oADDR_WR_1;
  logic [ADDR_W-1:0]  oADDR_WR_2;
  logic [ADDR_W-1:0]  oADDR_WR_3;
  logic               oWE_0;
  logic               oWE_1;
  logic               oWE_2;
  logic               oWE_3;
  logic               oSTART;
  logic               oBUSY;
  logic               oDONE;
  logic [7:0]         oFRAME_CNT;

  modport master (
    output iEN, iVALID, iSAMPLE, iFFT_RDY,
    input  oREADY, oDATA, oADDR_WR_0, oADDR_WR_1, oADDR_WR_2, oADDR_WR_3,
    input  oWE_0, oWE_1, oWE_2, oWE_3, oSTART, oBUSY, oDONE, oFRAME_CNT
  );

  modport slave (
    input  iEN, iVALID, iSAMPLE, iFFT_RDY,
    output oREADY, oDATA, oADDR_WR_0, oADDR_WR_1, oADDR_WR_2, oADDR_WR_3,
    output oWE_0, oWE_1, oWE_2, oWE_3, oSTART, oBUSY, oDONE, oFRAME_CNT
  );
endinterface

// File: rtl/fft_input_loader.sv
// Streams one frame of real samples into four interleaved FFT RAM banks, starts the
// FFT core, then waits for a fresh rising edge of its ready flag before the next frame.
module fft_input_loader #(
  parameter int unsigned ADDR_W = 9
) (
  input logic              iCLK,
  input logic              iRESET,
  fft_input_loader_if.slave bus
);
  localparam int unsigned     IdxW    = ADDR_W + 2;
  localparam logic [IdxW-1:0] LastIdx = '1;

  typedef enum logic [1:0] {StIdle, StLoad, StStart, StWait} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              rdy_prev_q;
  logic              ready_q, start_q, done_q, busy_q;
  logic [15:0]       data_q;
  logic [ADDR_W-1:0] addr_q [4];
  logic [3:0]        we_q;
  logic [7:0]        cnt_q;

  logic accept;
  logic rdy_rise;

  assign accept   = (state_q == StLoad) && bus.iVALID;
  assign rdy_rise = bus.iFFT_RDY && !rdy_prev_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (bus.iEN) begin
          state_d = StLoad;
          idx_d   = '0;
        end
      end
      StLoad: begin
        if (accept) begin
          // The last index wraps the counter back to zero on its own.
          idx_d = idx_q + IdxW'(1);
          if (idx_q == LastIdx) state_d = StStart;
        end
      end
      StStart: state_d = StWait;
      StWait: begin
        if (rdy_rise) begin
          state_d = bus.iEN ? StLoad : StIdle;
          idx_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (!iRESET) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      rdy_prev_q <= 1'b0;
      ready_q    <= 1'b0;
      start_q    <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      data_q     <= '0;
      we_q       <= '0;
      cnt_q      <= '0;
      for (int i = 0; i < 4; i++) addr_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      rdy_prev_q <= bus.iFFT_RDY;
      // Ready and busy follow the next state so they line up with the registered FSM.
      ready_q    <= (state_d == StLoad);
      busy_q     <= (state_d != StIdle);
      start_q    <= (state_q == StStart);
      done_q     <= (state_q == StWait) && rdy_rise;
      we_q       <= '0;
      if (accept) begin
        data_q              <= bus.iSAMPLE;
        we_q[idx_q[1:0]]    <= 1'b1;
        addr_q[idx_q[1:0]]  <= idx_q[IdxW-1:2];
      end
      if ((state_q == StWait) && rdy_rise) cnt_q <= cnt_q + 8'd1;
    end
  end

  assign bus.oREADY     = ready_q;
  assign bus.oDATA      = data_q;
  assign bus.oADDR_WR_0 = addr_q[0];
  assign bus.oADDR_WR_1 = addr_q[1];
  assign bus.oADDR_WR_2 = addr_q[2];
  assign bus.oADDR_WR_3 = addr_q[3];
  assign bus.oWE_0      = we_q[0];
  assign bus.oWE_1      = we_q[1];
  assign bus.oWE_2      = we_q[2];
  assign bus.oWE_3      = we_q[3];
  assign bus.oSTART     = start_q;
  assign bus.oBUSY      = busy_q;
  assign bus.oDONE      = done_q;
  assign bus.oFRAME_CNT = cnt_q;
endmodule

// File: tb/tb_fft_input_loader.sv
// Directed bench for fft_input_loader with a small frame (ADDR_W=3) and a
// behavioural phase model checked against every output on every cycle.
module tb_fft_input_loader;
  localparam int unsigned AW    = 3;
  localparam int          FRAME = 4 * (1 << AW);
  localparam int M_IDLE = 0, M_LOAD = 1, M_START = 2, M_WAIT = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fft_input_loader_if #(.ADDR_W(AW)) bus ();
  fft_input_loader #(.ADDR_W(AW)) dut (.iCLK(clk), .iRESET(rst_n), .bus(bus));

  int nvec = 0, nmis = 0;

  // Model state and expected outputs.
  int          m_mode, m_n;
  bit          m_prev;
  bit          e_ready, e_start, e_done, e_busy;
  logic [3:0]  e_we;
  int          e_addr [4];
  logic [15:0] e_data;
  int          e_cnt;

  int ram [4][1 << AW];
  int done_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nmis++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      m_mode = M_IDLE; m_n = 0; m_prev = 0;
      e_ready = 0; e_start = 0; e_done = 0; e_busy = 0; e_we = '0;
      for (int k = 0; k < 4; k++) e_addr[k] = 0;
      e_data = '0; e_cnt = 0;
      return;
    end
    e_we = '0; e_start = 0; e_done = 0;
    case (m_mode)
      M_IDLE: if (bus.iEN) begin m_mode = M_LOAD; m_n = 0; end
      M_LOAD: if (bus.iVALID) begin
        e_we[m_n % 4]   = 1'b1;
        e_addr[m_n % 4] = m_n / 4;
        e_data          = bus.iSAMPLE;
        if (m_n == FRAME - 1) begin m_n = 0; m_mode = M_START; end
        else m_n++;
      end
      M_START: begin e_start = 1; m_mode = M_WAIT; end
      M_WAIT: if (bus.iFFT_RDY && !m_prev) begin
        e_done = 1;
        e_cnt  = (e_cnt + 1) % 256;
        m_mode = bus.iEN ? M_LOAD : M_IDLE;
        m_n    = 0;
      end
      default: m_mode = M_IDLE;
    endcase
    m_prev  = bus.iFFT_RDY;
    e_ready = (m_mode == M_LOAD);
    e_busy  = (m_mode != M_IDLE);
  endtask

  task automatic compare();
    logic [3:0] we;
    int ad [4];
    we = {bus.oWE_3, bus.oWE_2, bus.oWE_1, bus.oWE_0};
    ad[0] = bus.oADDR_WR_0; ad[1] = bus.oADDR_WR_1;
    ad[2] = bus.oADDR_WR_2; ad[3] = bus.oADDR_WR_3;
    chk("oREADY", bus.oREADY, e_ready);
    chk("oWE", we, e_we);
    for (int k = 0; k < 4; k++) chk("oADDR_WR", ad[k], e_addr[k]);
    chk("oDATA", bus.oDATA, e_data);
    chk("oSTART", bus.oSTART, e_start);
    chk("oBUSY", bus.oBUSY, e_busy);
    chk("oDONE", bus.oDONE, e_done);
    chk("oFRAME_CNT", bus.oFRAME_CNT, e_cnt);
    for (int k = 0; k < 4; k++) if (we[k]) ram[k][ad[k]] = bus.oDATA;
    if (bus.oDONE) done_cnt++;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic clear_ram();
    for (int k = 0; k < 4; k++)
      for (int a = 0; a < (1 << AW); a++) ram[k][a] = -1;
  endtask

  // Bank k must hold 4a+k at address a when sample n carries value n.
  task automatic check_ram();
    for (int k = 0; k < 4; k++)
      for (int a = 0; a < (1 << AW); a++) chk("ram_image", ram[k][a], 4 * a + k);
  endtask

  task automatic load_frame(input int gap_pct, input int drop_en_at);
    int acc, budget;
    bit r, v;
    acc = 0; budget = 0;
    while (acc < FRAME && budget < 20 * FRAME) begin
      bus.iVALID  = ($urandom_range(99) >= gap_pct);
      bus.iSAMPLE = acc[15:0];
      if (acc == drop_en_at) bus.iEN = 1'b0;
      r = bus.oREADY; v = bus.iVALID;
      step();
      if (r && v) acc++;
      budget++;
    end
    bus.iVALID = 1'b0;
    chk("frame_accepts", acc, FRAME);
    chk("ready_low_after_last", bus.oREADY, 0);
    chk("last_write_no_start", bus.oSTART, 0);
    step();
    chk("start_two_after_last", bus.oSTART, 1);
  endtask

  initial begin
    bus.iEN = 0; bus.iVALID = 0; bus.iSAMPLE = '0; bus.iFFT_RDY = 0;
    rst_n = 0;
    repeat (3) step();
    chk("reset_busy", bus.oBUSY, 0);
    chk("reset_cnt", bus.oFRAME_CNT, 0);
    rst_n = 1;
    step();

    // Continuous frame, iEN dropped during WAIT returns to IDLE.
    bus.iEN = 1;
    clear_ram();
    load_frame(0, -1);
    check_ram();
    bus.iEN = 0;
    repeat (2) step();
    bus.iFFT_RDY = 1;
    step();
    chk("done_pulse_a", bus.oDONE, 1);
    chk("cnt_after_a", bus.oFRAME_CNT, 1);
    chk("model_cnt_a", e_cnt, 1);
    step();
    chk("idle_after_a", bus.oBUSY, 0);

    // Gapped frame, iEN dropped mid-load, iFFT_RDY already high entering WAIT.
    bus.iEN = 1;
    clear_ram();
    done_cnt = 0;
    load_frame(50, 10);
    check_ram();
    repeat (5) step();
    chk("no_done_on_held_high", done_cnt, 0);
    bus.iFFT_RDY = 0;
    repeat (3) step();
    bus.iFFT_RDY = 1;
    step();
    chk("done_on_rerise", bus.oDONE, 1);
    chk("cnt_after_b", bus.oFRAME_CNT, 2);
    repeat (3) step();
    chk("single_done_b", done_cnt, 1);
    chk("idle_after_b", bus.oBUSY, 0);
    bus.iFFT_RDY = 0;

    // Reset in the middle of a frame.
    bus.iEN = 1; bus.iVALID = 1;
    for (int i = 0; i < 20; i++) begin bus.iSAMPLE = 16'(i); step(); end
    rst_n = 0;
    step();
    chk("rst_we0", bus.oWE_0, 0);
    chk("rst_busy", bus.oBUSY, 0);
    chk("rst_cnt", bus.oFRAME_CNT, 0);
    rst_n = 1;
    bus.iSAMPLE = 16'sd123;
    repeat (2) step();
    chk("post_rst_we0", bus.oWE_0, 1);
    chk("post_rst_addr0", bus.oADDR_WR_0, 0);
    chk("post_rst_data", bus.oDATA, 123);
    bus.iVALID = 0;
    rst_n = 0;
    step();
    rst_n = 1;

    // 257 back-to-back frames: counter wrap and WAIT -> LOAD.
    bus.iEN = 1;
    for (int f = 0; f < 257; f++) begin
      load_frame(0, -1);
      bus.iFFT_RDY = 1;
      step();
      chk("done_b2b", bus.oDONE, 1);
      chk("wait_to_load", bus.oREADY, 1);
      if (f == 0)   chk("cnt_first", bus.oFRAME_CNT, 1);
      if (f == 254) chk("cnt_255", bus.oFRAME_CNT, 255);
      if (f == 255) chk("cnt_wrap", bus.oFRAME_CNT, 0);
      if (f == 256) chk("cnt_after_wrap", bus.oFRAME_CNT, 1);
      bus.iFFT_RDY = 0;
    end
    bus.iEN = 0;
    repeat (2) step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule

// File: doc/fft_input_loader.md
FFT_INPUT_LOADER -- requirements
Module: fft_input_loader

Interface
REQ-001 SHALL have parameter ADDR_W, 9, per-bank address width; frame length = 4*2^ADDR_W (2048 at default).
REQ-002 SHALL have port iCLK, input, 1, single clock; all logic on its rising edge.
REQ-003 SHALL have port iRESET, input, 1, reset; synchronous, active-low.
REQ-004 SHALL have port iEN, input, 1, arm loader; level.
REQ-005 SHALL have port iVALID, input, 1, upstream sample valid.
REQ-006 SHALL have port iSAMPLE, input, 16, signed two's-complement real sample.
REQ-007 SHALL have port oREADY, output, 1, loader accepts sample this cycle.
REQ-008 SHALL have port oDATA, output, 16, write data to all four FFT RAM banks.
REQ-009 SHALL have ports oADDR_WR_0..oADDR_WR_3, output, ADDR_W each, per-bank write address.
REQ-010 SHALL have ports oWE_0..oWE_3, output, 1 each, per-bank write enable.
REQ-011 SHALL have port oSTART, output, 1, one-cycle start pulse to FFT core.
REQ-012 SHALL have port iFFT_RDY, input, 1, FFT core ready/done level.
REQ-013 SHALL have port oBUSY, output, 1, high in any state except IDLE.
REQ-014 SHALL have port oDONE, output, 1, one-cycle pulse at frame completion.
REQ-015 SHALL have port oFRAME_CNT, output, 8, completed-frame counter.

Function
REQ-016 SHALL implement FSM IDLE, LOAD, START, WAIT; all outputs registered.
REQ-017 IDLE -> LOAD when iEN=1; index counter cleared to 0 on entry to LOAD.
REQ-018 oREADY SHALL be 1 only in LOAD; sample accepted on any edge with iVALID=1 and oREADY=1.
REQ-019 Accepted sample index n: bank = n[1:0], address = n[ADDR_W+1:2].
REQ-020 Write latency 1 cycle: accept at edge k -> oDATA=iSAMPLE, oADDR_WR_bank=address, oWE_bank=1 during cycle after edge k; other oWE_x=0.
REQ-021 oWE_x SHALL be 0 in every cycle without an acceptance on the preceding edge; unselected addresses hold previous values.
REQ-022 iVALID=0 in LOAD: no write, index holds; gaps of any length allowed.
REQ-023 Acceptance of index 4*2^ADDR_W-1: oREADY=0 from next cycle, FSM -> START; index wraps to 0.
REQ-024 START: oSTART=1 exactly one cycle, issued the cycle after the last oWE (two cycles after last acceptance); then -> WAIT.
REQ-025 WAIT: SHALL detect rising edge of iFFT_RDY (registered previous value); a level already high on WAIT entry SHALL NOT count.
REQ-026 On detected edge: oDONE=1 one cycle, oFRAME_CNT += 1 modulo 256 (255 -> 0), then -> LOAD if iEN=1 else IDLE.
REQ-027 iEN deasserted during LOAD/START/WAIT SHALL NOT abort; current frame completes.
REQ-028 iVALID during START/WAIT/IDLE SHALL be ignored (oREADY=0, no write).

Reset
REQ-029 iRESET=0 sampled at an edge SHALL force IDLE, index=0, oFRAME_CNT=0, oREADY=0, oWE_x=0, oSTART=0, oDONE=0, oBUSY=0, oDATA=0, oADDR_WR_x=0, edge-detect register=0.
REQ-030 Reset mid-LOAD/WAIT SHALL discard the partial frame; next frame restarts at index 0 with no pending oSTART/oDONE.

Verification
REQ-031 Full frame, iVALID=1 continuous, samples 0..2047 -> bank k receives value 4a+k at address a; oSTART one pulse 2 cycles after last acceptance.
REQ-032 Random iVALID gaps (~50%) -> identical RAM contents as REQ-031; no write in gap cycles; oREADY low after 2048th acceptance.
REQ-033 iFFT_RDY held high entering WAIT, then low 3 cycles, then high -> single oDONE on the re-rise; oFRAME_CNT 0 -> 1.
REQ-034 iEN high for 257 back-to-back frames -> oFRAME_CNT wraps 255 -> 0 -> 1; FSM goes WAIT -> LOAD directly.
REQ-035 iRESET=0 at sample 1000 -> all outputs zero next cycle; after release and iEN=1, first write goes to bank 0 address 0.
REQ-036 iEN dropped mid-LOAD -> frame completes, oDONE pulses, FSM returns to IDLE, oBUSY=0.
